// File: rtl/sr2_operand_stage_if.sv
// Operand-stage bus: upstream request, write-back forward port, downstream operand.
// master drives requests and consumes operands; slave is the stage itself.
interface sr2_operand_stage_if #(
  parameter int WIDTH     = 16,
  parameter int RF_ADDR_W = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     ir;
  logic [RF_ADDR_W-1:0] sr2_addr;
  logic [WIDTH-1:0]     sr2_from_rf;
  logic [1:0]           mode;
  logic                 wb_en;
  logic [RF_ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]     wb_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     sr2;
  logic                 out_is_imm;

  modport slave (
    input  in_valid, ir, sr2_addr, sr2_from_rf, mode,
    input  wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, sr2, out_is_imm
  );

  modport master (
    output in_valid, ir, sr2_addr, sr2_from_rf, mode,
    output wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, sr2, out_is_imm
  );
endinterface

// File: rtl/sr2_operand_stage.sv
// SR2 operand select with a two-entry skid buffer.
// Optional write-back forwarding: define SR2_FORWARD_EN.
module sr2_operand_stage #(
  parameter int WIDTH     = 16,
  parameter int RF_ADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  sr2_operand_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_imm_q, main_imm_d;
  logic             skid_imm_q, skid_imm_d;

  logic [WIDTH-1:0] imm5_w;
  logic [WIDTH-1:0] off6_w;
  logic [WIDTH-1:0] reg_w;
  logic [WIDTH-1:0] sel_w;
  logic             sel_imm_w;
  logic             in_fire;
  logic             out_fire;

  assign imm5_w = {{(WIDTH-5){bus.ir[4]}}, bus.ir[4:0]};
  assign off6_w = {{(WIDTH-6){bus.ir[5]}}, bus.ir[5:0]};

`ifdef SR2_FORWARD_EN
  assign reg_w = (bus.wb_en && bus.wb_addr == bus.sr2_addr)
               ? bus.wb_data : bus.sr2_from_rf;
`else
  assign reg_w = bus.sr2_from_rf;
  logic unused_fwd;
  assign unused_fwd = ^{bus.wb_en, bus.wb_addr, bus.wb_data,
                        bus.sr2_addr};
`endif

  logic unused_ir;
  assign unused_ir = ^bus.ir[WIDTH-1:6];

  always_comb begin
    sel_w     = reg_w;
    sel_imm_w = 1'b0;
    unique case (bus.mode)
      2'b00: begin
        sel_w     = bus.ir[5] ? imm5_w : reg_w;
        sel_imm_w = bus.ir[5];
      end
      2'b01: begin
        sel_w     = reg_w;
        sel_imm_w = 1'b0;
      end
      2'b10: begin
        sel_w     = imm5_w;
        sel_imm_w = 1'b1;
      end
      2'b11: begin
        sel_w     = off6_w;
        sel_imm_w = 1'b1;
      end
      default: begin
        sel_w     = reg_w;
        sel_imm_w = 1'b0;
      end
    endcase
  end

  assign bus.in_ready   = (state_q != TWO) && rst_n;
  assign bus.out_valid  = (state_q != EMPTY);
  assign bus.sr2        = main_q;
  assign bus.out_is_imm = main_imm_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    main_imm_d = main_imm_q;
    skid_d     = skid_q;
    skid_imm_d = skid_imm_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d    = ONE;
          main_d     = sel_w;
          main_imm_d = sel_imm_w;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d     = sel_w;
          main_imm_d = sel_imm_w;
        end else if (in_fire) begin
          state_d    = TWO;
          skid_d     = sel_w;
          skid_imm_d = sel_imm_w;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain path exists
        if (out_fire) begin
          state_d    = ONE;
          main_d     = skid_q;
          main_imm_d = skid_imm_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      main_imm_q <= 1'b0;
      skid_q     <= '0;
      skid_imm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      main_imm_q <= main_imm_d;
      skid_q     <= skid_d;
      skid_imm_q <= skid_imm_d;
    end
  end

endmodule

// File: tb/tb_sr2_operand_stage.sv
// Bench for sr2_operand_stage: queue model plus directed literal vectors.
module tb_sr2_operand_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sr2_operand_stage_if #(.WIDTH(16), .RF_ADDR_W(3)) bus ();

  sr2_operand_stage #(.WIDTH(16), .RF_ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] model_op(
    input logic [15:0] ir_v, input logic [1:0] m,
    input logic [15:0] rf, input logic we,
    input logic [2:0] wa, input logic [2:0] ra,
    input logic [15:0] wd);
    logic signed [5:0] o6;
    logic signed [4:0] i5;
    o6 = ir_v[5:0];
    i5 = ir_v[4:0];
    if (m == 2'b11) return {1'b1, 16'(o6)};
    if (m == 2'b10 || (m == 2'b00 && ir_v[5])) return {1'b1, 16'(i5)};
`ifdef SR2_FORWARD_EN
    if (we && wa == ra) return {1'b0, wd};
`endif
    return {1'b0, rf};
  endfunction

  logic [16:0] q[$];
  bit acc, pop;
  int nfire = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      acc = bus.in_valid && q.size() < 2;
      pop = bus.out_ready && q.size() > 0;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(model_op(bus.ir, bus.mode, bus.sr2_from_rf,
                                    bus.wb_en, bus.wb_addr, bus.sr2_addr,
                                    bus.wb_data));
    end
    if (rst_n && bus.out_valid && bus.out_ready) nfire++;
  end

  always @(negedge clk) begin
    check("in_ready", 32'(bus.in_ready), 32'(rst_n && q.size() < 2));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("sr2", 32'(bus.sr2), 32'(q[0][15:0]));
      check("out_is_imm", 32'(bus.out_is_imm), 32'(q[0][16]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] ir_v, input logic [1:0] m,
                       input logic [15:0] rf);
    bus.ir          = ir_v;
    bus.mode        = m;
    bus.sr2_from_rf = rf;
  endtask

  task automatic req_lit(input string name, input logic [15:0] ir_v,
                         input logic [1:0] m, input logic [15:0] rf,
                         input logic [15:0] exp, input logic exp_imm);
    drive(ir_v, m, rf);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check(name, 32'(bus.sr2), 32'(exp));
    check({name, "_imm"}, 32'(bus.out_is_imm), 32'(exp_imm));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int drops;
    int base;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b1;
    bus.ir          = 16'h1234;
    bus.mode        = 2'b00;
    bus.sr2_addr    = 3'd0;
    bus.sr2_from_rf = 16'h0;
    bus.wb_en       = 1'b0;
    bus.wb_addr     = 3'd0;
    bus.wb_data     = 16'h0;
    step();
    step();
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sr2", 32'(bus.sr2), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();

    req_lit("m00_imm", 16'h1234, 2'b00, 16'hBEEF, 16'hFFF4, 1'b1);
    req_lit("m00_reg", 16'h1214, 2'b00, 16'hBEEF, 16'hBEEF, 1'b0);
    req_lit("m11_neg", 16'h0020, 2'b11, 16'h7777, 16'hFFE0, 1'b1);
    req_lit("m11_pos", 16'h001F, 2'b11, 16'h7777, 16'h001F, 1'b1);
    req_lit("m01_reg", 16'h1234, 2'b01, 16'hCAFE, 16'hCAFE, 1'b0);
    req_lit("m10_imm", 16'h0030, 2'b10, 16'hCAFE, 16'hFFF0, 1'b1);

    bus.sr2_addr = 3'd3;
    bus.wb_en    = 1'b1;
    bus.wb_addr  = 3'd3;
    bus.wb_data  = 16'h5A5A;
`ifdef SR2_FORWARD_EN
    req_lit("fwd", 16'h0000, 2'b01, 16'h1111, 16'h5A5A, 1'b0);
`else
    req_lit("fwd", 16'h0000, 2'b01, 16'h1111, 16'h1111, 1'b0);
`endif
    req_lit("fwd_imm", 16'h0025, 2'b00, 16'h1111, 16'h0005, 1'b1);
    bus.wb_en = 1'b0;
    step();

    // back-pressure: three requests held off, then drained in order
    bus.out_ready = 1'b0;
    drive(16'h0, 2'b01, 16'd1);
    bus.in_valid = 1'b1;
    step();
    drive(16'h0, 2'b01, 16'd2);
    step();
    drive(16'h0, 2'b01, 16'd3);
    @(negedge clk);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("bp_first", 32'(bus.sr2), 32'd1);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_out1", 32'(bus.sr2), 32'd1);
    step();
    @(negedge clk);
    check("bp_out2", 32'(bus.sr2), 32'd2);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_out3", 32'(bus.sr2), 32'd3);
    step();
    step();

    // reset discards buffered entries
    bus.out_ready = 1'b0;
    drive(16'h0, 2'b01, 16'hAAAA);
    bus.in_valid = 1'b1;
    step();
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_sr2", 32'(bus.sr2), 32'h0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();

    // idle input toggling must not create entries
    for (int i = 0; i < 4; i++) begin
      drive(16'(i * 16'h1357), 2'(i), 16'(i));
      step();
    end

    // streaming: 100 requests, one per cycle
    base  = nfire;
    edges = 0;
    drops = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(16'(i * 16'h0101), 2'(i % 4), 16'(16'h4000 + i));
      if (!bus.in_ready) drops++;
      step();
      edges++;
    end
    bus.in_valid = 1'b0;
    while (nfire - base < 100 && edges < 120) begin
      step();
      edges++;
    end
    check("stream_count", 32'(nfire - base), 32'd100);
    check("stream_cycles", 32'(edges), 32'd101);
    check("stream_drops", 32'(drops), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
